// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy state enum and per-boundary control structs/widths for pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} pipe_occ_e;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_op;
    logic [4:0] rd;
  } idex_ctrl_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } exmem_ctrl_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } memwb_ctrl_t;
  localparam int IDEX_CTRL_W  = $bits(idex_ctrl_t);
  localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);
  localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one {valid,data,ctrl} entry; ports clk, rst, i_flush, i_load, i_clear, i_data, i_ctrl -> o_valid, o_data, o_ctrl
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 16,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_load && !i_flush) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end else if (i_flush || i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (CLEAR_DATA != 0) r_data <= '0;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with flush and optional skid entry; ports clk, rst, flush, in_valid/in_ready/in_data/in_ctrl, out_valid/out_ready/out_data/out_ctrl, occ
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 16,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);
  logic              w_in_fire, w_out_fire, w_m_load, w_s_valid;
  logic [DATA_W-1:0] w_s_data, w_m_data;
  logic [CTRL_W-1:0] w_s_ctrl, w_m_ctrl;
  pipe_occ_e         w_state;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  // main refills from skid first to keep FIFO order, otherwise from input when it is free or draining
  assign w_m_load = (w_in_fire & (!out_valid | w_out_fire)) | (w_s_valid & w_out_fire);
  assign w_m_data = w_s_valid ? w_s_data : in_data;
  assign w_m_ctrl = w_s_valid ? w_s_ctrl : in_ctrl;
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
    .clk(clk), .rst(rst), .i_flush(flush), .i_load(w_m_load), .i_clear(w_out_fire),
    .i_data(w_m_data), .i_ctrl(w_m_ctrl),
    .o_valid(out_valid), .o_data(out_data), .o_ctrl(out_ctrl)
  );
  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
        .clk(clk), .rst(rst), .i_flush(flush), .i_load(w_in_fire & out_valid & !w_out_fire),
        .i_clear(w_out_fire), .i_data(in_data), .i_ctrl(in_ctrl),
        .o_valid(w_s_valid), .o_data(w_s_data), .o_ctrl(w_s_ctrl)
      );
      assign in_ready = !w_s_valid & !rst;
    end else begin : g_noskid
      assign w_s_valid = 1'b0;
      assign w_s_data  = '0;
      assign w_s_ctrl  = '0;
      assign in_ready  = (!out_valid | out_ready) & !rst;
    end
  endgenerate
  assign w_state = pipe_occ_e'({w_s_valid, out_valid & !w_s_valid});
  assign occ     = w_state;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven plus scoreboard bench for pipe_stage_reg (skid/clear-data and no-skid/hold-data instances)
module tb_pipe_stage_reg;
  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [15:0] c;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_od;
    logic [15:0] e_oc;
    logic [1:0]  e_occ;
    logic        e_ir;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    logic [15:0] c;
  } beat_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic [15:0] in_ctrl = 0;
  logic in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0] occ;
  logic f0 = 0, iv0 = 0, or0 = 0, ir0, ov0;
  logic [31:0] id0 = 0, od0;
  logic [15:0] ic0 = 0, oc0;
  logic [1:0] occ0;
  int n_cmp = 0, n_bad = 0;
  bit mon_on = 0;
  beat_t q[$];
  vec_t tv[17];
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CLEAR_DATA(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occ(occ)
  );
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CLEAR_DATA(0)) dut0 (
    .clk(clk), .rst(rst), .flush(f0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .in_ctrl(ic0), .out_valid(ov0), .out_ready(or0),
    .out_data(od0), .out_ctrl(oc0), .occ(occ0)
  );
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction
  always @(negedge clk) begin
    if (mon_on) begin
      chk("sb_occ", 32'(occ), 32'(q.size()));
      chk("sb_in_ready", 32'(in_ready), 32'(!rst && q.size() < 2));
      chk("sb_out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (rst) q.delete();
      else begin
        if (out_valid && out_ready && q.size() != 0) begin
          beat_t e;
          e = q.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_ctrl", 32'(out_ctrl), 32'(e.c));
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back('{in_data, in_ctrl});
      end
    end
  end
  task automatic drive(input vec_t v, input int k);
    @(posedge clk);
    #1;
    in_valid = v.iv; in_data = v.d; in_ctrl = v.c; out_ready = v.ordy; flush = v.fl;
    @(negedge clk);
    chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(v.e_ov));
    chk($sformatf("v%0d_out_data", k), out_data, v.e_od);
    chk($sformatf("v%0d_out_ctrl", k), 32'(out_ctrl), 32'(v.e_oc));
    chk($sformatf("v%0d_occ", k), 32'(occ), 32'(v.e_occ));
    chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(v.e_ir));
  endtask
  initial begin
    tv[0]  = '{1, 32'h100, 16'h1,    1, 0, 0, 32'h0,   16'h0,    2'd0, 1};
    tv[1]  = '{1, 32'h104, 16'h2,    1, 0, 1, 32'h100, 16'h1,    2'd1, 1};
    tv[2]  = '{1, 32'h108, 16'h3,    1, 0, 1, 32'h104, 16'h2,    2'd1, 1};
    tv[3]  = '{1, 32'hA,   16'h4,    1, 0, 1, 32'h108, 16'h3,    2'd1, 1};
    tv[4]  = '{1, 32'hB,   16'h5,    0, 0, 1, 32'hA,   16'h4,    2'd1, 1};
    tv[5]  = '{1, 32'hC0,  16'h6,    0, 0, 1, 32'hA,   16'h4,    2'd2, 0};
    tv[6]  = '{0, 32'h0,   16'h0,    1, 0, 1, 32'hA,   16'h4,    2'd2, 0};
    tv[7]  = '{0, 32'h0,   16'h0,    1, 0, 1, 32'hB,   16'h5,    2'd1, 1};
    tv[8]  = '{0, 32'h0,   16'h0,    0, 0, 0, 32'h0,   16'h0,    2'd0, 1};
    tv[9]  = '{1, 32'h11,  16'hFFFF, 0, 0, 0, 32'h0,   16'h0,    2'd0, 1};
    tv[10] = '{1, 32'h12,  16'hFFFF, 0, 0, 1, 32'h11,  16'hFFFF, 2'd1, 1};
    tv[11] = '{1, 32'hC,   16'hFFFF, 0, 1, 1, 32'h11,  16'hFFFF, 2'd2, 0};
    tv[12] = '{0, 32'h0,   16'h0,    0, 0, 0, 32'h0,   16'h0,    2'd0, 1};
    tv[13] = '{1, 32'h21,  16'h7,    0, 0, 0, 32'h0,   16'h0,    2'd0, 1};
    tv[14] = '{1, 32'h22,  16'h8,    1, 0, 1, 32'h21,  16'h7,    2'd1, 1};
    tv[15] = '{1, 32'h23,  16'h9,    1, 1, 1, 32'h22,  16'h8,    2'd1, 1};
    tv[16] = '{0, 32'h0,   16'h0,    1, 0, 0, 32'h0,   16'h0,    2'd0, 1};
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    mon_on = 1;
    for (int k = 0; k < 17; k++) drive(tv[k], k);
    drive('{1, 32'h31, 16'h31, 0, 0, 0, 32'h0,  16'h0,  2'd0, 1}, 17);
    drive('{1, 32'h32, 16'h32, 0, 0, 1, 32'h31, 16'h31, 2'd1, 1}, 18);
    @(posedge clk);
    #1;
    rst = 1; in_data = 32'h33;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_occ_before", 32'(occ), 32'd2);
    @(posedge clk);
    #1;
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk("post_rst_out_data", out_data, 32'h0);
    chk("post_rst_out_ctrl", 32'(out_ctrl), 32'h0);
    chk("post_rst_occ", 32'(occ), 32'h0);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    iv0 = 1; id0 = 32'h55; ic0 = 16'h3; or0 = 0;
    @(negedge clk);
    chk("ns_in_ready_empty", 32'(ir0), 32'h1);
    @(posedge clk);
    #1;
    id0 = 32'h66; ic0 = 16'h6;
    @(negedge clk);
    chk("ns_out_valid", 32'(ov0), 32'h1);
    chk("ns_out_data", od0, 32'h55);
    chk("ns_in_ready_full", 32'(ir0), 32'h0);
    or0 = 1;
    #1;
    chk("ns_in_ready_comb", 32'(ir0), 32'h1);
    @(posedge clk);
    #1;
    iv0 = 0;
    @(negedge clk);
    chk("ns_next_data", od0, 32'h66);
    chk("ns_next_ctrl", 32'(oc0), 32'h6);
    chk("ns_next_occ", 32'(occ0), 32'h1);
    @(posedge clk);
    #1;
    or0 = 0;
    @(negedge clk);
    chk("ns_empty_valid", 32'(ov0), 32'h0);
    chk("ns_empty_ctrl", 32'(oc0), 32'h0);
    chk("ns_hold_data", od0, 32'h66);
    chk("ns_empty_occ", 32'(occ0), 32'h0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
